// File: rtl/ds_adc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ds_adc_pkg : shared types and elaboration helpers for ds_comp_adc_array
// Rev 1.0
// ----------------------------------------------------------------------------
package ds_adc_pkg;

  localparam int MAX_CHANNELS = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // Bits needed for an unsigned 1-bit-input CIC output: order*log2(R) growth plus the input bit.
  function automatic int cic_min_width(input int stages, input int decim);
    return stages * $clog2(decim) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ds_cic_decimator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ds_cic_decimator : single-channel CIC filter driven by a shared decimation tick
// Rev 1.0
// ----------------------------------------------------------------------------
module ds_cic_decimator
  import ds_adc_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int WIDTH  = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_bit,
  input  logic             i_tick,
  output logic [WIDTH-1:0] o_filt
);

  logic [WIDTH-1:0] r_int  [STAGES];
  logic [WIDTH-1:0] r_dly  [STAGES];
  logic [WIDTH-1:0] w_comb [STAGES+1];

  always_comb begin
    w_comb[0] = r_int[STAGES-1];
    for (int k = 0; k < STAGES; k++) begin
      w_comb[k+1] = w_comb[k] - r_dly[k];
    end
  end

  // Modulo-2^WIDTH wrap in the integrators is intentional; the combs cancel it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_int[k] <= '0;
        r_dly[k] <= '0;
      end
      o_filt <= '0;
    end else begin
      r_int[0] <= r_int[0] + {{(WIDTH-1){1'b0}}, i_bit};
      for (int k = 1; k < STAGES; k++) begin
        r_int[k] <= r_int[k] + r_int[k-1];
      end
      if (i_tick) begin
        for (int k = 0; k < STAGES; k++) begin
          r_dly[k] <= w_comb[k];
        end
        o_filt <= w_comb[STAGES];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ds_comp_adc_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ds_comp_adc_array : N-channel delta-sigma comparator ADC with CIC and frame serialiser
// Rev 1.0
// ----------------------------------------------------------------------------
module ds_comp_adc_array
  import ds_adc_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int STAGES     = 2,
  parameter int DECIMATION = 32,
  parameter int WIDTH      = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] cmp_in,
  output logic [CHANNELS-1:0] pdm_out,
  input  logic                trigger,
  input  logic                diff_en,
  output logic                ser_out,
  output logic                ser_valid,
  output logic                busy,
  output logic                sample_strobe,
  output logic                data_ready
);

  localparam int c_CNT_W  = $clog2(DECIMATION);
  localparam int c_WORD_W = $clog2(CHANNELS + 1);
  localparam int c_BIT_W  = $clog2(WIDTH);
  localparam int c_SCNT_W = $clog2(STAGES + 2);

  if (WIDTH < cic_min_width(STAGES, DECIMATION) + 1 ||
      (DECIMATION & (DECIMATION - 1)) != 0 ||
      CHANNELS < 2 || CHANNELS > MAX_CHANNELS) begin : g_bad_params
    $error("ds_comp_adc_array: illegal CHANNELS/STAGES/DECIMATION/WIDTH combination");
  end

  logic [CHANNELS-1:0] r_ff;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                w_tick;
  logic                r_strobe;
  logic [c_SCNT_W-1:0] r_scnt;
  logic                r_ready;
  logic [WIDTH-1:0]    w_filt [CHANNELS];

  logic                r_sync1, r_sync2, r_sync3;
  logic                w_edge;
  ser_state_e          r_state, w_next;
  logic                w_accept;
  logic [WIDTH-1:0]    r_shadow [CHANNELS+1];
  logic                r_diff_en;
  logic [c_WORD_W-1:0] r_word;
  logic [c_BIT_W-1:0]  r_bit;
  logic [c_WORD_W-1:0] w_last_word;
  logic                w_last_bit;

  assign pdm_out       = ~r_ff;
  assign w_tick        = (r_cnt == c_CNT_W'(DECIMATION - 1));
  assign sample_strobe = r_strobe;
  assign data_ready    = r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff     <= '1;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_scnt   <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ff     <= cmp_in;
      r_cnt    <= r_cnt + 1'b1;
      r_strobe <= w_tick;
      // The pipeline needs STAGES+1 outputs before the comb delays hold real history.
      if (r_strobe && !r_ready) begin
        if (r_scnt == c_SCNT_W'(STAGES)) r_ready <= 1'b1;
        else                             r_scnt  <= r_scnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    ds_cic_decimator #(
      .STAGES (STAGES),
      .WIDTH  (WIDTH)
    ) u_cic (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_bit  (r_ff[g]),
      .i_tick (w_tick),
      .o_filt (w_filt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= trigger;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge      = r_sync2 & ~r_sync3;
  assign w_accept    = (r_state == ST_IDLE) && w_edge;
  assign w_last_word = r_diff_en ? c_WORD_W'(CHANNELS) : c_WORD_W'(CHANNELS - 1);
  assign w_last_bit  = (r_word == w_last_word) && (r_bit == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_edge) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy      = 1'b1;
        ser_out   = r_shadow[r_word][r_bit];
        ser_valid = (r_bit == c_BIT_W'(WIDTH - 1));
        if (w_last_bit) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Shadows are written only on acceptance, so a frame never mixes sample periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c <= CHANNELS; c++) r_shadow[c] <= '0;
      r_diff_en <= 1'b0;
      r_word    <= '0;
      r_bit     <= '0;
    end else if (w_accept) begin
      for (int c = 0; c < CHANNELS; c++) r_shadow[c] <= w_filt[c];
      r_shadow[CHANNELS] <= w_filt[0] - w_filt[1];
      r_diff_en <= diff_en;
      r_word    <= '0;
      r_bit     <= c_BIT_W'(WIDTH - 1);
    end else if (r_state == ST_SHIFT) begin
      if (r_bit == '0) begin
        r_bit  <= c_BIT_W'(WIDTH - 1);
        r_word <= r_word + 1'b1;
      end else begin
        r_bit <= r_bit - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ds_comp_adc_array.md
# ds_comp_adc_array

Parametrised multi-channel delta-sigma comparator ADC core. It is the next generation of the team's two-channel comparator ADC top. It provides:
- N comparator channels, each with a flip-flop/inverter feedback stage.
- A CIC decimator of configurable order and decimation per channel.
- A trigger-driven frame serialiser that shifts all channels out on one pin, with an optional channel-0-minus-channel-1 difference word.

It sits between the pad-level comparator inputs / PDM feedback pins and the external readout MCU.

## Interface
- CHANNELS, 2: number of comparator channels (≥2 if DIFF used, max 8)
- STAGES, 2: CIC order (1..4)
- DECIMATION, 32: CIC decimation ratio, power of two (4..256)
- WIDTH, 13: filter/word width; must be ≥ STAGES*log2(DECIMATION)+2 (signed difference headroom)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmp_in  in  CHANNELS  comparator levels, already clk-domain
- pdm_out  out  CHANNELS  feedback drive = ~ff[i]
- trigger  in  1  asynchronous readout request, rising-edge sensitive
- diff_en  in  1  append (ch0 − ch1) word to frame; sampled on accepted trigger
- ser_out  out  1  serial data, MSB first
- ser_valid  out  1  high during MSB of every word
- busy  out  1  high while a frame is shifting
- sample_strobe  out  1  one-cycle pulse when CIC outputs update
- data_ready  out  1  sticky; set once CIC pipeline has flushed after reset

## Operation
- **Front end.** Per channel `ff[i] <= cmp_in[i]`; reset value 1. `pdm_out[i] = ~ff[i]`, so it is 0 in reset.
- **CIC.**
  - STAGES integrators run every clk on `ff[i]` (0/1).
  - A shared decimation counter runs 0..DECIMATION−1 and wraps.
  - At count DECIMATION−1, STAGES comb stages evaluate and `filt[i]` registers the result.
  - `sample_strobe` pulses in the cycle after `filt` updates.
  - All arithmetic is two's complement, WIDTH bits, modulo wrap (required for CIC correctness). No saturation.
- **data_ready.** Sets after STAGES+1 strobes. Cleared only by reset.
- **Trigger path.**
  - `trigger` goes through a 2-flop synchroniser, then a rising-edge detector.
  - An edge accepted in IDLE does all of the following:
    - snapshots every `filt[i]` into shadow registers, taking the value registered in that cycle (pre-update if coincident with a decimation boundary);
    - snapshots `diff = filt[0] − filt[1]` (WIDTH bits, wrap);
    - latches `diff_en`;
    - enters SHIFT.
- **Serialiser FSM.**
  - IDLE: ser_out=0, ser_valid=0, busy=0.
  - SHIFT: word index w = 0..NW−1, where NW = CHANNELS + diff_en_latched. Bit counter b = WIDTH−1..0.
    - Output `shadow[w][b]`, one bit per clk.
    - `ser_valid` = (b == WIDTH−1).
    - After the last bit of the last word, return to IDLE.
  - Words go out in order ch0..ch(N−1), then diff.
  - Edges detected while busy are dropped, not queued.
  - Shadows are frozen during SHIFT, so the frame is atomic.
- **Reset.** Reset asserted mid-frame immediately aborts the frame. On release:
  - FSM is in IDLE;
  - all integrators, combs, filt, shadows and counters are 0;
  - the synchroniser flops are 0, so a trigger held high through reset produces one frame after release.

## Timing
- cmp_in to pdm_out: 1 cycle.
- CIC group update: once per DECIMATION cycles. First strobe at cycle DECIMATION after reset release.
- Trigger to first bit:
  - trigger high is first sampled at edge k;
  - the edge is accepted at edge k+2;
  - ser_out shows word0 MSB with ser_valid=1 from edge k+2 for one cycle.
- Frame length: NW*WIDTH cycles. busy is high exactly those cycles.
- The earliest next accepted trigger is the edge-detect cycle immediately after busy falls.

## Structure
- Package `ds_adc_pkg`:
  - serialiser state enum (IDLE, SHIFT);
  - function `cic_min_width(stages, decim)`;
  - max-channel constant.
- Elaboration-time check: WIDTH ≥ cic_min_width + 1; DECIMATION a power of two.
- Sub-module `ds_cic_decimator`: one CIC per channel, taking a shared decimation tick. It is instantiated CHANNELS times via generate.
- Synchroniser, edge detect, shadow registers and FSM live in the top.

## Test plan
- cmp_in all 1 for 4 decimation periods (defaults) → filt = 1024 each, pdm_out = 0, data_ready set after 3rd strobe.
- cmp_in ch0 = 1010… toggling, ch1 = 0 → filt0 = 512, filt1 = 0 in steady state.
- Steady ch0 = 1024, ch1 = 0, diff_en = 1, trigger pulse → 39-bit frame: 0x0400, 0x0000, 0x0400. ser_valid at bits 0, 13, 26; busy exactly 39 cycles; first bit at edge k+2.
- ch0 = 0, ch1 = 1024, diff_en = 0 then 1 → 26-bit frame without diff word; then a frame ending with diff word 0x1C00 (−1024 in 13-bit).
- Second trigger pulse 10 cycles into a frame → ignored; frame unchanged, no second frame. Trigger after busy falls → new frame.
- rst_n low at bit 20 of a frame → ser_out, ser_valid, busy = 0 immediately. After release there is no resumed frame and filt restarts from 0.
